pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and flow controller for the five-stage core (fetch, decode, execute, memory, writeback). Computes every stage's `stall`/`invalidate` pair, the fetch redirect request, and interrupt acceptance. It is driven by the per-stage `data_hazard` destination addresses, branch resolution, bus wait signals and writeback trap/mret/wfi flags. A small FSM sequences trap drain and wfi sleep.

## Interface
Parameters:
- `TRAP_DRAIN_CYCLES`, default 2: cycles fetch output is discarded after a trap redirect (range 1..15).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `decode_rs1`, `decode_rs2` in 5 each: source registers of the instruction in decode.
- `decode_uses_rs1`, `decode_uses_rs2` in 1 each: the corresponding source is read.
- `ex_hazard`, `mem_hazard`, `wb_hazard` in 5 each: pending rd of the execute, memory and writeback stages; 0 means none.
- `fetch_busy` in 1: instruction bus wait.
- `mem_busy` in 1: data bus wait in the memory stage.
- `branch_taken` in 1: a valid memory-stage instruction redirects control flow.
- `wb_trap`, `wb_mret`, `wb_wfi` in 1 each: a valid writeback instruction carries an exception, mret or wfi.
- `irq_pending` in 1: an enabled interrupt is pending.
- `stall_fetch`, `stall_decode`, `stall_execute`, `stall_memory` out 1 each: hold the stage register.
- `invalidate_fetch`, `invalidate_decode`, `invalidate_execute`, `invalidate_memory` out 1 each: the stage captures a bubble (valid=0).
- `redirect` out 1: fetch loads a new pc this cycle.
- `redirect_sel` out 2: pc source. 0 = branch target, 1 = mtvec, 2 = mepc.
- `take_irq` out 1: single-cycle pulse, interrupt accepted.
- `sleeping` out 1: core halted in wfi.

## Operation
- FSM states and transitions:
  - RUN: normal operation.
  - DRAIN: discard fetch output, counting down.
  - SLEEP: halted in wfi.
- Event priority in RUN, highest first:
  1. Trap/irq. Condition: `wb_trap` or (`irq_pending` && !`mem_busy`).
     - `redirect`=1, `redirect_sel`=1, all four invalidates=1.
     - Pulse `take_irq` when caused by irq without `wb_trap`.
     - Load counter with `TRAP_DRAIN_CYCLES`, go to DRAIN.
  2. `wb_mret`: `redirect`=1, `redirect_sel`=2, all four invalidates=1, stay in RUN.
  3. `branch_taken` (and !`mem_busy`): `redirect`=1, `redirect_sel`=0, invalidate fetch, decode and execute.
  4. `mem_busy`: all four stalls=1, no invalidates.
  5. Data hazard. Condition: a used source equals a nonzero `ex_hazard`/`mem_hazard`/`wb_hazard`.
     - `stall_fetch`=`stall_decode`=1, `invalidate_execute`=1.
  6. `fetch_busy`: `stall_fetch`=1, `invalidate_decode`=1.
- `wb_wfi` in RUN with no higher event: go to SLEEP (macro permitting).
- DRAIN:
  - `invalidate_decode`=1 every cycle; counter decrements.
  - Go to RUN when counter reaches 1 at the clock edge.
  - `mem_busy` still stalls the memory stage.
  - Any trap during DRAIN restarts DRAIN with the counter reloaded.
- SLEEP:
  - `sleeping`=1, `stall_fetch`=1, `invalidate_decode`=1.
  - `irq_pending` takes the trap path (1), which exits to DRAIN.
- Register x0 never causes a hazard.
- Outputs not set by the active rule are 0.

## Timing
- Stall, invalidate, redirect and `take_irq` are combinational from inputs and state: zero-cycle latency, and they act at the same clock edge.
- State and counter are registered.
- While `reset`=1:
  - state=RUN, counter=0.
  - All stalls=0, all invalidates=1, `redirect`=0, `redirect_sel`=0, `take_irq`=0, `sleeping`=0.
- Reset asserted mid-DRAIN or mid-SLEEP returns to RUN asynchronously.
- Simultaneous `wb_trap` and `branch_taken`: trap wins, `redirect_sel`=1.
- Simultaneous `wb_mret` and `irq_pending`: irq wins. mret is squashed and re-executes after the handler.
- Irq is never accepted while `mem_busy`=1, so no memory access is torn.
- `TRAP_DRAIN_CYCLES`=1: DRAIN lasts exactly one cycle.
- Counter width is 4 bits. The counter never wraps, because reload happens only on entry to DRAIN.

## Configuration
- `PIPELINE_CTRL_WFI_SLEEP_EN` defined: wfi enters SLEEP as described.
- `PIPELINE_CTRL_WFI_SLEEP_EN` undefined:
  - `wb_wfi` is ignored (executes as a nop).
  - SLEEP is unreachable and `sleeping` is tied to 0.

## Test plan
- Data hazard: `decode_rs1`=5, `decode_uses_rs1`=1, `ex_hazard`=5 → `stall_fetch`=`stall_decode`=`invalidate_execute`=1. With `ex_hazard`=0 instead → all outputs 0.
- Branch under bus wait: `branch_taken`=1 with `mem_busy`=1 → all stalls=1, `redirect`=0. Release `mem_busy` → `redirect`=1, `redirect_sel`=0, fetch/decode/execute invalidated.
- Trap drain: `wb_trap` pulse with `TRAP_DRAIN_CYCLES`=2 → `redirect_sel`=1 and all invalidates in that cycle. Then `invalidate_decode`=1 for exactly 2 cycles, then back to RUN.
- wfi wake (macro on): `wb_wfi`=1 → `sleeping`=1 from the next cycle. 10 idle cycles later `irq_pending`=1 → `take_irq`=1, `redirect_sel`=1, `sleeping`=0 next cycle. With the macro off → `sleeping` stays 0.
- Simultaneous events: `wb_mret`=1 and `irq_pending`=1 → `redirect_sel`=1, `take_irq`=1.
- Reset mid-operation: assert `reset` during SLEEP → `sleeping`=0 and all invalidates=1 immediately, with no clock edge required.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and flow controller for the five-stage core: per-stage stall/invalidate, fetch redirect, irq accept.
// Optional wfi sleep state is enabled by defining PIPELINE_CTRL_WFI_SLEEP_EN.
module pipeline_ctrl #(
   parameter int unsigned TRAP_DRAIN_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] decode_rs1,
   input  logic [4:0] decode_rs2,
   input  logic       decode_uses_rs1,
   input  logic       decode_uses_rs2,
   input  logic [4:0] ex_hazard,
   input  logic [4:0] mem_hazard,
   input  logic [4:0] wb_hazard,
   input  logic       fetch_busy,
   input  logic       mem_busy,
   input  logic       branch_taken,
   input  logic       wb_trap,
   input  logic       wb_mret,
   input  logic       wb_wfi,
   input  logic       irq_pending,
   output logic       stall_fetch,
   output logic       stall_decode,
   output logic       stall_execute,
   output logic       stall_memory,
   output logic       invalidate_fetch,
   output logic       invalidate_decode,
   output logic       invalidate_execute,
   output logic       invalidate_memory,
   output logic       redirect,
   output logic [1:0] redirect_sel,
   output logic       take_irq,
   output logic       sleeping
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned REG_W = 5;
   localparam logic [1:0] SEL_BRANCH = 2'd0;
   localparam logic [1:0] SEL_MTVEC  = 2'd1;
   localparam logic [1:0] SEL_MEPC   = 2'd2;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SLEEP = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             hazard;
   logic             trap_cond;

   function automatic logic reg_match(input logic [REG_W-1:0] src, input logic [REG_W-1:0] rd);
      return (rd != '0) && (src == rd);
   endfunction

   // Read-after-write against any in-flight destination; x0 never matches.
   always_comb begin
      hazard = (decode_uses_rs1 && (reg_match(decode_rs1, ex_hazard) ||
                                    reg_match(decode_rs1, mem_hazard) ||
                                    reg_match(decode_rs1, wb_hazard))) ||
               (decode_uses_rs2 && (reg_match(decode_rs2, ex_hazard) ||
                                    reg_match(decode_rs2, mem_hazard) ||
                                    reg_match(decode_rs2, wb_hazard)));
   end

   // Interrupts wait for the data bus so no memory access is torn.
   assign trap_cond = wb_trap || (irq_pending && !mem_busy);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt          = state;
      cnt_nxt            = cnt;
      stall_fetch        = 1'b0;
      stall_decode       = 1'b0;
      stall_execute      = 1'b0;
      stall_memory       = 1'b0;
      invalidate_fetch   = 1'b0;
      invalidate_decode  = 1'b0;
      invalidate_execute = 1'b0;
      invalidate_memory  = 1'b0;
      redirect           = 1'b0;
      redirect_sel       = SEL_BRANCH;
      take_irq           = 1'b0;
      sleeping           = 1'b0;

      if (reset) begin
         invalidate_fetch   = 1'b1;
         invalidate_decode  = 1'b1;
         invalidate_execute = 1'b1;
         invalidate_memory  = 1'b1;
      end else if (trap_cond) begin
         // Trap or irq wins in every state and (re)starts the drain.
         redirect           = 1'b1;
         redirect_sel       = SEL_MTVEC;
         invalidate_fetch   = 1'b1;
         invalidate_decode  = 1'b1;
         invalidate_execute = 1'b1;
         invalidate_memory  = 1'b1;
         take_irq           = !wb_trap;
         cnt_nxt            = CNT_W'(TRAP_DRAIN_CYCLES);
         state_nxt          = DRAIN;
      end else begin
         case (state)
            RUN: begin
               if (wb_mret) begin
                  redirect           = 1'b1;
                  redirect_sel       = SEL_MEPC;
                  invalidate_fetch   = 1'b1;
                  invalidate_decode  = 1'b1;
                  invalidate_execute = 1'b1;
                  invalidate_memory  = 1'b1;
               end else if (branch_taken && !mem_busy) begin
                  redirect           = 1'b1;
                  redirect_sel       = SEL_BRANCH;
                  invalidate_fetch   = 1'b1;
                  invalidate_decode  = 1'b1;
                  invalidate_execute = 1'b1;
               end else if (mem_busy) begin
                  stall_fetch   = 1'b1;
                  stall_decode  = 1'b1;
                  stall_execute = 1'b1;
                  stall_memory  = 1'b1;
               end else if (hazard) begin
                  stall_fetch        = 1'b1;
                  stall_decode       = 1'b1;
                  invalidate_execute = 1'b1;
               end else if (fetch_busy) begin
                  stall_fetch       = 1'b1;
                  invalidate_decode = 1'b1;
               end else begin
`ifdef PIPELINE_CTRL_WFI_SLEEP_EN
                  if (wb_wfi) begin
                     state_nxt = SLEEP;
                  end
`endif
               end
            end
            DRAIN: begin
               invalidate_decode = 1'b1;
               stall_memory      = mem_busy;
               cnt_nxt           = cnt - CNT_W'(1);
               if (cnt <= CNT_W'(1)) begin
                  state_nxt = RUN;
               end
            end
            SLEEP: begin
`ifdef PIPELINE_CTRL_WFI_SLEEP_EN
               sleeping          = 1'b1;
               stall_fetch       = 1'b1;
               invalidate_decode = 1'b1;
`else
               state_nxt = RUN;
`endif
            end
            default: state_nxt = RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (default TRAP_DRAIN_CYCLES=2).
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_WFI_SLEEP_EN
   localparam bit WFI_ON = 1'b1;
`else
   localparam bit WFI_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] decode_rs1, decode_rs2;
   logic       decode_uses_rs1, decode_uses_rs2;
   logic [4:0] ex_hazard, mem_hazard, wb_hazard;
   logic       fetch_busy, mem_busy, branch_taken;
   logic       wb_trap, wb_mret, wb_wfi, irq_pending;
   logic       stall_fetch, stall_decode, stall_execute, stall_memory;
   logic       invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory;
   logic       redirect;
   logic [1:0] redirect_sel;
   logic       take_irq, sleeping;

   int errors = 0;
   int checks = 0;

   logic [12:0] exp_q[$];
   string       name_q[$];
   logic [12:0] exp_v, act_v;
   string       nm;

   pipeline_ctrl dut (
      .clk(clk), .reset(reset),
      .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
      .decode_uses_rs1(decode_uses_rs1), .decode_uses_rs2(decode_uses_rs2),
      .ex_hazard(ex_hazard), .mem_hazard(mem_hazard), .wb_hazard(wb_hazard),
      .fetch_busy(fetch_busy), .mem_busy(mem_busy), .branch_taken(branch_taken),
      .wb_trap(wb_trap), .wb_mret(wb_mret), .wb_wfi(wb_wfi), .irq_pending(irq_pending),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode),
      .stall_execute(stall_execute), .stall_memory(stall_memory),
      .invalidate_fetch(invalidate_fetch), .invalidate_decode(invalidate_decode),
      .invalidate_execute(invalidate_execute), .invalidate_memory(invalidate_memory),
      .redirect(redirect), .redirect_sel(redirect_sel),
      .take_irq(take_irq), .sleeping(sleeping)
   );

   always #5 clk = ~clk;

   // Expected word: {stall f,d,e,m, inv f,d,e,m, redirect, sel[1:0], take_irq, sleeping}
   function automatic logic [12:0] mk(input logic [3:0] st, input logic [3:0] inv,
                                      input logic red, input logic [1:0] sel,
                                      input logic ti, input logic sl);
      return {st, inv, red, sel, ti, sl};
   endfunction

   // Monitor: outputs are combinational, so check mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         act_v = {stall_fetch, stall_decode, stall_execute, stall_memory,
                  invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory,
                  redirect, redirect_sel, take_irq, sleeping};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act_v, exp_v);
         end
      end
   end

   task automatic clr();
      decode_rs1 = '0; decode_rs2 = '0;
      decode_uses_rs1 = 1'b0; decode_uses_rs2 = 1'b0;
      ex_hazard = '0; mem_hazard = '0; wb_hazard = '0;
      fetch_busy = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
      wb_trap = 1'b0; wb_mret = 1'b0; wb_wfi = 1'b0; irq_pending = 1'b0;
   endtask

   task automatic step(input string name, input logic [12:0] e);
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] ALL  = 4'b1111;

   logic [12:0] e_sleep;

   initial begin
      e_sleep = WFI_ON ? mk(4'b1000, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b1) : mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0);
      reset = 1'b1;
      clr();
      @(posedge clk);
      #1;

      step("reset", mk(NONE, ALL, 1'b0, 2'd0, 1'b0, 1'b0));
      reset = 1'b0;
      step("idle", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));

      clr(); decode_rs1 = 5'd5; decode_uses_rs1 = 1'b1; ex_hazard = 5'd5;
      step("hazard_ex_rs1", mk(4'b1100, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0));
      ex_hazard = 5'd0;
      step("no_hazard_ex0", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));
      clr(); decode_rs2 = 5'd7; decode_uses_rs2 = 1'b1; mem_hazard = 5'd7;
      step("hazard_mem_rs2", mk(4'b1100, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0));
      clr(); decode_rs1 = 5'd9; decode_uses_rs1 = 1'b1; wb_hazard = 5'd9;
      step("hazard_wb_rs1", mk(4'b1100, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0));
      clr(); decode_rs1 = 5'd3; ex_hazard = 5'd3;
      step("unused_src", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));
      clr(); fetch_busy = 1'b1;
      step("fetch_busy", mk(4'b1000, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      decode_rs1 = 5'd4; decode_uses_rs1 = 1'b1; ex_hazard = 5'd4;
      step("hazard_over_fetch", mk(4'b1100, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0));

      clr(); branch_taken = 1'b1; mem_busy = 1'b1;
      step("branch_mem_busy", mk(ALL, NONE, 1'b0, 2'd0, 1'b0, 1'b0));
      mem_busy = 1'b0;
      step("branch_release", mk(NONE, 4'b1110, 1'b1, 2'd0, 1'b0, 1'b0));

      clr(); wb_trap = 1'b1; branch_taken = 1'b1;
      step("trap_vs_branch", mk(NONE, ALL, 1'b1, 2'd1, 1'b0, 1'b0));
      clr();
      step("drain1", mk(NONE, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      step("drain2", mk(NONE, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      step("after_drain", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));

      clr(); wb_mret = 1'b1; irq_pending = 1'b1;
      step("irq_vs_mret", mk(NONE, ALL, 1'b1, 2'd1, 1'b1, 1'b0));
      clr(); mem_busy = 1'b1;
      step("drain_mem_busy", mk(4'b0001, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      clr(); wb_trap = 1'b1;
      step("trap_in_drain", mk(NONE, ALL, 1'b1, 2'd1, 1'b0, 1'b0));
      clr();
      step("redrain1", mk(NONE, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      step("redrain2", mk(NONE, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      step("after_redrain", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));

      clr(); wb_mret = 1'b1;
      step("mret", mk(NONE, ALL, 1'b1, 2'd2, 1'b0, 1'b0));
      clr(); irq_pending = 1'b1; mem_busy = 1'b1;
      step("irq_blocked_mem_busy", mk(ALL, NONE, 1'b0, 2'd0, 1'b0, 1'b0));

      clr(); wb_wfi = 1'b1;
      step("wfi", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));
      clr();
      for (int i = 0; i < 10; i++) step("sleep_idle", e_sleep);
      irq_pending = 1'b1;
      step("wake_irq", mk(NONE, ALL, 1'b1, 2'd1, 1'b1, 1'b0));
      clr();
      step("wake_drain1", mk(NONE, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      step("wake_drain2", mk(NONE, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
      step("wake_run", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));

      wb_wfi = 1'b1;
      step("wfi2", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));
      clr();
      step("sleep2", e_sleep);
      reset = 1'b1;
      step("reset_mid_sleep", mk(NONE, ALL, 1'b0, 2'd0, 1'b0, 1'b0));
      reset = 1'b0;
      step("post_reset_run", mk(NONE, NONE, 1'b0, 2'd0, 1'b0, 1'b0));

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
      end
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
